// File: rtl/bt_cmd_ctrl.sv
// Bluetooth command controller: parses A5/CMD/ARG/CHK frames, arbitrates manual vs
// autopilot motion, gates forward motion on obstacles and stops on link loss.
module bt_cmd_ctrl #(
  parameter logic [7:0]  HDR     = 8'hA5,
  parameter int unsigned BYTE_TO = 1_000_000,
  parameter int unsigned LINK_TO = 100_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_vld,
  input  logic [7:0] RXData,
  input  logic       AUTO_vld,
  input  logic [2:0] AUTO_dir,
  input  logic [7:0] AUTO_spd,
  input  logic       OBST,
  output logic [2:0] DIR,
  output logic [7:0] SPD,
  output logic       MODE,
  output logic       CMD_upd,
  output logic       FRAME_err,
  output logic       LINK_ok
);

  localparam logic [31:0] BYTE_LAST = 32'(BYTE_TO - 1);
  localparam logic [31:0] LINK_LAST = 32'(LINK_TO - 1);

  typedef enum logic [1:0] {IDLE, GET_CMD, GET_ARG, GET_CHK} state_t;

  state_t      state, state_n;
  logic [31:0] byte_tmr, byte_tmr_n;
  logic [31:0] wdog, wdog_n;
  logic [7:0]  cmd_r, arg_r;
  logic [2:0]  man_dir, man_dir_n, auto_dir, auto_dir_n, sel_dir, dir_n;
  logic [7:0]  man_spd, man_spd_n, auto_spd, auto_spd_n, sel_spd, spd_n;
  logic        mode_n, link_n, frame_ok, frame_bad, cmd_defined, chk_match;

  assign cmd_defined = (cmd_r <= 8'h04) || (cmd_r == 8'h10) || (cmd_r == 8'h11);
  assign chk_match   = (8'(cmd_r + arg_r) == RXData);

  always_comb begin
    state_n    = state;
    byte_tmr_n = byte_tmr;
    frame_ok   = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      IDLE: begin
        byte_tmr_n = '0;
        if (RX_vld && RXData == HDR) state_n = GET_CMD;
      end
      default: begin
        if (RX_vld) begin
          byte_tmr_n = '0;
          case (state)
            GET_CMD: state_n = GET_ARG;
            GET_ARG: state_n = GET_CHK;
            default: begin
              state_n = IDLE;
              if (chk_match && cmd_defined) frame_ok  = 1'b1;
              else                          frame_bad = 1'b1;
            end
          endcase
        end else if (byte_tmr + 32'd1 == BYTE_LAST) begin
          // Inter-byte gap too long: abandon the partial frame
          state_n    = IDLE;
          byte_tmr_n = '0;
          frame_bad  = 1'b1;
        end else begin
          byte_tmr_n = byte_tmr + 32'd1;
        end
      end
    endcase
  end

  always_comb begin
    wdog_n     = wdog;
    link_n     = LINK_ok;
    man_dir_n  = man_dir;
    man_spd_n  = man_spd;
    mode_n     = MODE;
    auto_dir_n = auto_dir;
    auto_spd_n = auto_spd;
    if (frame_ok) begin
      wdog_n = '0;
      link_n = 1'b1;
      if (cmd_r[4] == 1'b0) begin
        man_dir_n = cmd_r[2:0];
        man_spd_n = (cmd_r[2:0] == 3'd0) ? 8'd0 : arg_r;
        mode_n    = 1'b0;
      end else begin
        mode_n = cmd_r[0];
      end
    end else if (wdog != LINK_LAST) begin
      wdog_n = wdog + 32'd1;
      if (wdog + 32'd1 == LINK_LAST) begin
        link_n    = 1'b0;
        man_dir_n = 3'd0;
        man_spd_n = 8'd0;
      end
    end
    if (AUTO_vld) begin
      auto_dir_n = (AUTO_dir > 3'd4) ? 3'd0 : AUTO_dir;
      auto_spd_n = (AUTO_dir > 3'd4) ? 8'd0 : AUTO_spd;
    end
    sel_dir = mode_n ? auto_dir_n : man_dir_n;
    sel_spd = mode_n ? auto_spd_n : man_spd_n;
    dir_n   = sel_dir;
    spd_n   = sel_spd;
    // Only forward motion is blocked by an obstacle; stop always carries zero speed
    if (sel_dir == 3'd0 || (OBST && sel_dir == 3'd1)) begin
      dir_n = 3'd0;
      spd_n = 8'd0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RX_vld && state == GET_CMD) cmd_r <= RXData;
    if (RX_vld && state == GET_ARG) arg_r <= RXData;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      byte_tmr  <= '0;
      wdog      <= '0;
      man_dir   <= '0;
      man_spd   <= '0;
      auto_dir  <= '0;
      auto_spd  <= '0;
      MODE      <= 1'b0;
      DIR       <= '0;
      SPD       <= '0;
      CMD_upd   <= 1'b0;
      FRAME_err <= 1'b0;
      LINK_ok   <= 1'b0;
    end else begin
      state     <= state_n;
      byte_tmr  <= byte_tmr_n;
      wdog      <= wdog_n;
      man_dir   <= man_dir_n;
      man_spd   <= man_spd_n;
      auto_dir  <= auto_dir_n;
      auto_spd  <= auto_spd_n;
      MODE      <= mode_n;
      DIR       <= dir_n;
      SPD       <= spd_n;
      CMD_upd   <= frame_ok;
      FRAME_err <= frame_bad;
      LINK_ok   <= link_n;
    end
  end

endmodule

// File: tb/tb_bt_cmd_ctrl.sv
// Directed bench for bt_cmd_ctrl with shortened byte and link timeouts.
module tb_bt_cmd_ctrl;

  localparam int unsigned BYTE_TO = 50;
  localparam int unsigned LINK_TO = 1000;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_vld = 1'b0;
  logic [7:0] RXData = 8'h00;
  logic       AUTO_vld = 1'b0;
  logic [2:0] AUTO_dir = 3'd0;
  logic [7:0] AUTO_spd = 8'h00;
  logic       OBST = 1'b0;
  logic [2:0] DIR;
  logic [7:0] SPD;
  logic       MODE, CMD_upd, FRAME_err, LINK_ok;

  int tests = 0;
  int failed = 0;

  bt_cmd_ctrl #(.HDR(8'hA5), .BYTE_TO(BYTE_TO), .LINK_TO(LINK_TO)) dut (
    .CLK(CLK), .RST(RST), .RX_vld(RX_vld), .RXData(RXData),
    .AUTO_vld(AUTO_vld), .AUTO_dir(AUTO_dir), .AUTO_spd(AUTO_spd), .OBST(OBST),
    .DIR(DIR), .SPD(SPD), .MODE(MODE), .CMD_upd(CMD_upd),
    .FRAME_err(FRAME_err), .LINK_ok(LINK_ok)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        failed++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic send(input logic [7:0] b);
    RX_vld = 1'b1;
    RXData = b;
    tick();
    RX_vld = 1'b0;
  endtask

  task automatic frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
    send(8'hA5); send(c); send(a); send(k);
  endtask

  task automatic auto_req(input logic [2:0] d, input logic [7:0] s);
    AUTO_vld = 1'b1; AUTO_dir = d; AUTO_spd = s;
    tick();
    AUTO_vld = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [2:0] d, input logic [7:0] s,
                         input logic m, input logic l);
    chk({tag, ".dir"}, 32'(DIR), 32'(d));
    chk({tag, ".spd"}, 32'(SPD), 32'(s));
    chk({tag, ".mode"}, 32'(MODE), 32'(m));
    chk({tag, ".link"}, 32'(LINK_ok), 32'(l));
  endtask

  initial begin
    tick(); tick();
    chk_out("reset", 3'd0, 8'h00, 1'b0, 1'b0);
    chk("reset.upd", 32'(CMD_upd), 0);
    chk("reset.err", 32'(FRAME_err), 0);
    RST = 1'b0;
    tick();

    frame(8'h01, 8'h80, 8'h81);
    chk_out("fwd", 3'd1, 8'h80, 1'b0, 1'b1);
    chk("fwd.upd", 32'(CMD_upd), 1);
    chk("fwd.err", 32'(FRAME_err), 0);
    tick();
    chk("fwd.upd_drop", 32'(CMD_upd), 0);

    frame(8'h02, 8'h40, 8'h00);
    chk("badchk.err", 32'(FRAME_err), 1);
    chk("badchk.upd", 32'(CMD_upd), 0);
    chk_out("badchk", 3'd1, 8'h80, 1'b0, 1'b1);
    tick();
    chk("badchk.err_drop", 32'(FRAME_err), 0);

    send(8'h33);
    chk("junk.err", 32'(FRAME_err), 0);
    frame(8'h03, 8'h20, 8'h23);
    chk_out("left", 3'd3, 8'h20, 1'b0, 1'b1);
    chk("left.upd", 32'(CMD_upd), 1);

    send(8'hA5); send(8'h01);
    for (int i = 0; i < int'(BYTE_TO) - 2; i++) tick();
    chk("bto.early", 32'(FRAME_err), 0);
    tick();
    chk("bto.err", 32'(FRAME_err), 1);
    chk("bto.dir_hold", 32'(DIR), 3);
    tick();
    chk("bto.err_drop", 32'(FRAME_err), 0);
    frame(8'h04, 8'h10, 8'h14);
    chk_out("right", 3'd4, 8'h10, 1'b0, 1'b1);

    frame(8'h11, 8'h00, 8'h11);
    chk("auto.upd", 32'(CMD_upd), 1);
    chk_out("auto_empty", 3'd0, 8'h00, 1'b1, 1'b1);
    auto_req(3'd1, 8'h50);
    chk_out("auto_fwd", 3'd1, 8'h50, 1'b1, 1'b1);
    OBST = 1'b1;
    tick();
    chk_out("obst_on", 3'd0, 8'h00, 1'b1, 1'b1);
    OBST = 1'b0;
    tick();
    chk_out("obst_off", 3'd1, 8'h50, 1'b1, 1'b1);
    auto_req(3'd6, 8'h77);
    chk_out("auto_bad_dir", 3'd0, 8'h00, 1'b1, 1'b1);
    OBST = 1'b1;
    auto_req(3'd2, 8'h60);
    chk_out("obst_back", 3'd2, 8'h60, 1'b1, 1'b1);
    OBST = 1'b0;
    auto_req(3'd1, 8'h50);
    chk_out("auto_reload", 3'd1, 8'h50, 1'b1, 1'b1);

    frame(8'h02, 8'h30, 8'h32);
    chk_out("override", 3'd2, 8'h30, 1'b0, 1'b1);

    frame(8'h01, 8'h80, 8'h81);
    for (int i = 0; i < int'(LINK_TO) - 2; i++) tick();
    chk_out("wd_man.before", 3'd1, 8'h80, 1'b0, 1'b1);
    tick();
    chk_out("wd_man.expire", 3'd0, 8'h00, 1'b0, 1'b0);

    frame(8'h11, 8'h00, 8'h11);
    chk_out("wd_auto.start", 3'd1, 8'h50, 1'b1, 1'b1);
    for (int i = 0; i < int'(LINK_TO) - 2; i++) tick();
    chk("wd_auto.before", 32'(LINK_ok), 1);
    tick();
    chk_out("wd_auto.expire", 3'd1, 8'h50, 1'b1, 1'b0);

    frame(8'h10, 8'h00, 8'h10);
    send(8'hA5); send(8'h01);
    RST = 1'b1;
    #1;
    chk_out("rst_mid", 3'd0, 8'h00, 1'b0, 1'b0);
    chk("rst_mid.upd", 32'(CMD_upd), 0);
    tick();
    RST = 1'b0;
    send(8'h01); send(8'h80); send(8'h81);
    chk("nohdr.upd", 32'(CMD_upd), 0);
    chk("nohdr.err", 32'(FRAME_err), 0);
    chk("nohdr.dir", 32'(DIR), 0);
    tick();
    chk("nohdr.upd2", 32'(CMD_upd), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/bt_cmd_ctrl.md
# bt_cmd_ctrl

Command controller between the Bluetooth UART byte receiver and the motor/steering logic. Parses 4-byte framed commands from the receiver's byte strobe, arbitrates between manual (Bluetooth) and autopilot motion requests, and applies obstacle gating. A link watchdog forces a stop when the phone link goes silent.

## Interface
- HDR, 8'hA5, frame header byte
- BYTE_TO, 1_000_000, max cycles between frame bytes (10 ms at 100 MHz)
- LINK_TO, 100_000_000, cycles without a valid frame before link loss (1 s)
- CLK  in  1  system clock, 100 MHz
- RST  in  1  asynchronous, active-high reset
- RX_vld  in  1  one-cycle strobe: RXData holds a received byte
- RXData  in  8  received byte
- AUTO_vld  in  1  one-cycle strobe: autopilot request valid
- AUTO_dir  in  3  autopilot direction (encoding as DIR)
- AUTO_spd  in  8  autopilot speed
- OBST  in  1  obstacle ahead (level)
- DIR  out  3  0 stop, 1 fwd, 2 back, 3 left, 4 right
- SPD  out  8  speed; 0 whenever DIR=0
- MODE  out  1  0 manual, 1 auto
- CMD_upd  out  1  one-cycle pulse: valid frame accepted
- FRAME_err  out  1  one-cycle pulse: frame rejected
- LINK_ok  out  1  1 while the watchdog has not expired

## Operation
- Frame: HDR, CMD, ARG, CHK, with CHK = (CMD + ARG) mod 256.
- CMD 8'h00–8'h04: direction = CMD[2:0], speed = ARG (ARG ignored for 8'h00, speed 0). CMD 8'h10: MODE := 0. CMD 8'h11: MODE := 1. ARG ignored for mode commands.
- Parser FSM: IDLE → GET_CMD → GET_ARG → GET_CHK → IDLE, advancing on each RX_vld.
  - IDLE: a byte != HDR is discarded silently.
  - GET_*: every byte is data, including HDR.
  - At GET_CHK, a checksum mismatch or an undefined CMD gives FRAME_err and a return to IDLE with no state change.
- Byte timer: cleared on every RX_vld; counts in GET_CMD, GET_ARG and GET_CHK. On reaching BYTE_TO-1: FRAME_err, go to IDLE.
- Valid direction frame: loads the manual registers and sets MODE := 0 (manual override, even when in auto).
- Auto registers: load AUTO_dir/AUTO_spd on AUTO_vld regardless of MODE.
- Source selection: MODE=0 uses the manual registers; MODE=1 uses the auto registers.
- Obstacle gating: if OBST=1 and the selected direction is 1 (fwd), then DIR=0, SPD=0. Back, left and right are not gated.
- Watchdog (32-bit counter):
  - Cleared, with LINK_ok := 1, on every valid frame.
  - Otherwise increments, saturating at LINK_TO-1.
  - On reaching LINK_TO-1: LINK_ok := 0, manual registers := stop/0.
  - Auto mode output is unaffected by the watchdog.
- Any byte with a DIR code above 4 from AUTO_dir is treated as stop.

## Timing
- Reset values: DIR=0, SPD=0, MODE=0, CMD_upd=0, FRAME_err=0, LINK_ok=0. FSM is in IDLE and all counters are 0. Reset mid-frame discards the partial frame.
- All outputs are registered. The edge that samples the CHK byte updates DIR/SPD/MODE and raises CMD_upd (latency 1 cycle from the CHK strobe).
- An AUTO_vld sampled at edge N is reflected on DIR/SPD at edge N (visible from the following cycle) when MODE=1.
- A change on OBST is reflected on DIR/SPD after 1 edge.
- FRAME_err and CMD_upd are never high in the same cycle. Each is exactly 1 cycle wide.
- Simultaneous events:
  - Valid frame and AUTO_vld: frame wins; MODE=0; the auto registers still load.
  - Valid frame and watchdog expiry: frame wins; LINK_ok stays 1.
  - RX_vld and byte-timeout in the same cycle: the byte is accepted and the timer is cleared.
- A mode command that matches the current MODE still pulses CMD_upd and clears the watchdog.

## Test plan
- Reset, then frame A5 01 80 81 → CMD_upd pulse; DIR=1, SPD=8'h80, MODE=0, LINK_ok=1 one edge after the CHK strobe.
- Frame A5 02 40 00 (bad CHK) → FRAME_err pulse; DIR/SPD unchanged. Then bytes 33 A5 03 20 23 → no error for 33; DIR=3, SPD=8'h20.
- Bytes A5 01, then BYTE_TO cycles idle → FRAME_err at cycle BYTE_TO-1; the next A5 04 10 14 is accepted, giving DIR=4, SPD=8'h10.
- Send A5 11 00 11, then AUTO_vld with dir 1 / spd 8'h50 → MODE=1, DIR=1, SPD=8'h50.
  - Raise OBST → DIR=0, SPD=0 after 1 edge. Drop OBST → restored.
  - Then A5 02 30 32 → MODE=0, DIR=2.
- Manual DIR=1/SPD=8'h80, then no frames for LINK_TO cycles (LINK_TO reduced to 1000 in the bench) → LINK_ok=0, DIR=0, SPD=0 at cycle 999. Repeat in auto mode → LINK_ok=0, DIR/SPD hold the auto values.
- Assert RST after A5 01 mid-frame → all outputs at their reset values. After release, frame 01 80 81 without a header is ignored.
